// File: rtl/memory_controller_if.sv
// Request/response and memory-side signal bundle for memory_controller.
// slave = the controller itself; master = the requester plus the memory_system it drives.
interface memory_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] mem_data;
  logic [1:0] mem_addr;
  logic       mem_store;
  logic [7:0] mem_q;

  modport slave (
    input  req_valid, req_write, req_addr, req_data, mem_q,
    output req_ready, rsp_valid, rsp_data, busy, mem_data, mem_addr, mem_store
  );

  modport master (
    output req_valid, req_write, req_addr, req_data, mem_q,
    input  req_ready, rsp_valid, rsp_data, busy, mem_data, mem_addr, mem_store
  );
endinterface

// File: rtl/memory_controller.sv
// Sequences single-cycle read/write requests into a glitch-free setup/strobe/hold
// pattern for a level-sensitive 4-byte store, and returns reads on a one-cycle strobe.
module memory_controller #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned READ_WAIT     = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  memory_controller_if.slave   bus,
  output logic [2:0]           dbg_state_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_RWAIT  = 3'd4;

  // Counter counts down from N-1 so each phase lasts exactly N cycles.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] RWAIT_LD  = 4'(READ_WAIT - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_data_q, mem_data_d;
  logic       mem_store_q, mem_store_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;

  // Handshake: a request transfers at the rising edge where req_valid && req_ready;
  // req_ready is high exactly while IDLE, and req_* are ignored at every other edge.
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.mem_store = mem_store_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign dbg_state_o   = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_store_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          mem_addr_d = bus.req_addr;
          if (bus.req_write) begin
            mem_data_d = bus.req_data;
            state_d    = ST_SETUP;
            cnt_d      = SETUP_LD;
          end else begin
            state_d = ST_RWAIT;
            cnt_d   = RWAIT_LD;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_STROBE;
          cnt_d       = STROBE_LD;
          mem_store_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d       = cnt_q - 4'd1;
          mem_store_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RWAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_IDLE;
          cnt_d       = 4'd0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.mem_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      mem_addr_q  <= 2'd0;
      mem_data_q  <= 8'd0;
      mem_store_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_store_q <= mem_store_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Sequencing stage directly upstream of the 4-byte memory_system: turns single-cycle read/write requests into the timed data/addr/store pattern the level-sensitive byte stores need.
- Drives memory_system's data/addr/store inputs and samples its memory output.
- Returns read data on a one-cycle response strobe.
- Guarantees a stable setup/strobe/hold sequence, so no stray writes occur while the address changes.

Parameters:
- SETUP_CYCLES, 1: cycles mem_addr/mem_data are stable with mem_store low before the strobe.
- STROBE_CYCLES, 2: cycles mem_store is held high.
- HOLD_CYCLES, 1: cycles mem_addr/mem_data are held after mem_store falls.
- READ_WAIT, 1: cycles between driving mem_addr and sampling mem_q.
- All parameters range 1..15; internal 4-bit cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  2  byte address 0..3.
- req_data  input  8  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse, read data valid.
- rsp_data  output  8  read result, held until the next read completes.
- busy  output  1  high whenever the FSM is not IDLE.
- mem_data  output  8  to memory_system data.
- mem_addr  output  2  to memory_system addr.
- mem_store  output  1  to memory_system store.
- mem_q  input  8  from memory_system memory.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values: state IDLE, mem_store 0, mem_addr 0, mem_data 0, rsp_valid 0, rsp_data 0, busy 0, req_ready 1.
- Output registering: all mem_* outputs and rsp_* are registered. mem_store is a flop output and never glitches.
- FSM states: IDLE, SETUP, STROBE, HOLD, RWAIT.
- req_ready = (state == IDLE); it is combinational from the state register.
- Accept: at the edge where req_valid && req_ready, latch mem_addr <= req_addr and load the counter.
  - Write: also mem_data <= req_data, go to SETUP.
  - Read: go to RWAIT; mem_data is unchanged.
- SETUP: lasts SETUP_CYCLES cycles with mem_store 0, then STROBE. mem_store rises at the same edge as the STROBE entry.
- STROBE: mem_store 1 for exactly STROBE_CYCLES cycles, then HOLD. mem_store falls at the same edge as the HOLD entry.
- HOLD: lasts HOLD_CYCLES cycles, then IDLE. A write produces no response.
- RWAIT: lasts READ_WAIT cycles. At the final edge: rsp_data <= mem_q, rsp_valid <= 1 for one cycle, state goes to IDLE.
- Back-to-back requests: a new request may be accepted in the cycle rsp_valid is high.
- Write latency with defaults, accept at edge E0:
  - SETUP after E0.
  - mem_store high after E1 through E3.
  - HOLD after E3.
  - req_ready high after E4.
  - Next accept possible at E5.
- Read latency with defaults: accept at E0, rsp_valid high in the cycle after E1.
- mem_addr and mem_data hold their last value in IDLE. mem_store is 0 in every state except STROBE.
- req_valid while not ready: ignored (no queueing). req_addr, req_data and req_write are sampled only at accept.
- Reset mid-operation:
  - mem_store drops to 0 immediately, asynchronously.
  - The FSM returns to IDLE, the counter clears, and no rsp_valid is produced.
  - The target byte may or may not have captured data; memory_system contents are not cleared.
- X on req_* while req_valid is 0 must not affect state.

Test Plan:
- Reset, then write addr 2, data 0xA5 with defaults -> mem_store high exactly 2 cycles; mem_addr = 2 and mem_data = 0xA5 stable one cycle before and after; req_ready low 4 cycles.
- Write 0x11/0x22/0x33/0x44 to addr 0..3, then read addr 0..3 -> rsp_data 0x11, 0x22, 0x33, 0x44, each with a single-cycle rsp_valid one cycle after the cycle following accept.
- Hold req_valid high with back-to-back reads -> accepts only when req_ready = 1; each read response pulse coincides with the next accept.
- Write addr 1 = 0x5A, then read addr 3 (previously 0x44) -> rsp_data 0x44; addr 3 unchanged; no mem_store assertion during the read.
- Assert reset_n low during STROBE of a write to addr 0 -> mem_store 0 asynchronously, all outputs at reset values, req_ready 1 after release; a following read of addr 1 returns its prior value.
- Set STROBE_CYCLES = 5, SETUP_CYCLES = 3, READ_WAIT = 2 -> store pulse width 5, strobe rises 3 cycles after accept, read response 2 cycles after accept.
